// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and constants for the VRAM arbiter
package vram_pkg;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_CPU  = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 32;
    localparam int READ_LATENCY = 3;
    localparam int STREAK_W     = 4;

endpackage

// File: rtl/vram_grant_logic.sv
// rtl/vram_grant_logic.sv - display/CPU priority decision and next streak value
module vram_grant_logic
    import vram_pkg::*;
#(
    parameter int MAX_DISP_STREAK = 4
) (
    input  logic                disp_req_i_unused_guard,
    input  logic                i_disp_req,
    input  logic                i_cpu_req,
    input  logic                i_in_blank,
    input  logic [STREAK_W-1:0] i_streak,
    output logic                o_grant_valid,
    output owner_t              o_grant_owner,
    output logic [STREAK_W-1:0] o_streak_next
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DISP_STREAK);

    logic w_unused;
    assign w_unused = disp_req_i_unused_guard;

    always_comb begin
        o_grant_valid = i_disp_req | i_cpu_req;
        o_grant_owner = OWN_DISP;
        o_streak_next = '0;
        if (i_cpu_req && (!i_disp_req || i_in_blank || (i_streak == STREAK_MAX))) begin
            o_grant_owner = OWN_CPU;
        end
        // The streak only measures how long a waiting CPU has been passed over.
        if (i_cpu_req && i_disp_req && (o_grant_owner == OWN_DISP)) begin
            o_streak_next = (i_streak == STREAK_MAX) ? i_streak : i_streak + 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM sharing between display scanout and CPU
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_DISP_STREAK = 4
) (
    input  logic              pixel_clock,
    input  logic              reset_n,
    input  logic              in_blank,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ready,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic                w_grant_valid;
    owner_t              w_grant_owner;
    logic [STREAK_W-1:0] w_streak_next;
    logic                w_grant_we;
    logic [ADDR_W-1:0]   w_grant_addr;

    logic [STREAK_W-1:0] r_streak;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    tag_t                r_tag0;
    tag_t                r_tag1;
    logic                r_disp_rvalid;
    logic [DATA_W-1:0]   r_disp_rdata;
    logic                r_cpu_rvalid;
    logic [DATA_W-1:0]   r_cpu_rdata;

    vram_grant_logic #(
        .MAX_DISP_STREAK(MAX_DISP_STREAK)
    ) u_grant (
        .disp_req_i_unused_guard(1'b0),
        .i_disp_req             (disp_req),
        .i_cpu_req              (cpu_req),
        .i_in_blank             (in_blank),
        .i_streak               (r_streak),
        .o_grant_valid          (w_grant_valid),
        .o_grant_owner          (w_grant_owner),
        .o_streak_next          (w_streak_next)
    );

    assign w_grant_we   = (w_grant_owner == OWN_CPU) && cpu_we;
    assign w_grant_addr = (w_grant_owner == OWN_CPU) ? cpu_addr : disp_addr;

    // Readies are gated by reset so nothing is acknowledged while the pipe is held clear.
    assign disp_ready = reset_n && w_grant_valid && (w_grant_owner == OWN_DISP);
    assign cpu_ready  = reset_n && w_grant_valid && (w_grant_owner == OWN_CPU);

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_streak      <= '0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_tag0        <= '0;
            r_tag1        <= '0;
            r_disp_rvalid <= 1'b0;
            r_disp_rdata  <= '0;
            r_cpu_rvalid  <= 1'b0;
            r_cpu_rdata   <= '0;
        end else begin
            r_streak <= w_streak_next;
            r_mem_en <= w_grant_valid;
            if (w_grant_valid) begin
                r_mem_we   <= w_grant_we;
                r_mem_addr <= w_grant_addr;
                if (w_grant_we) begin
                    r_mem_wdata <= cpu_wdata;
                end
            end
            // Writes never enter the tag pipe, so they cannot raise an rvalid.
            r_tag0        <= '{valid: w_grant_valid && !w_grant_we, owner: w_grant_owner};
            r_tag1        <= r_tag0;
            r_disp_rvalid <= r_tag1.valid && (r_tag1.owner == OWN_DISP);
            r_cpu_rvalid  <= r_tag1.valid && (r_tag1.owner == OWN_CPU);
            if (r_tag1.valid && (r_tag1.owner == OWN_DISP)) begin
                r_disp_rdata <= mem_rdata;
            end
            if (r_tag1.valid && (r_tag1.owner == OWN_CPU)) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign disp_rvalid = r_disp_rvalid;
    assign disp_rdata  = r_disp_rdata;
    assign cpu_rvalid  = r_cpu_rvalid;
    assign cpu_rdata   = r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed vector bench for vram_arbiter with a behavioural RAM
module tb_vram_arbiter;

    logic        pixel_clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_blank = 1'b0;
    logic        disp_req = 1'b0;
    logic [15:0] disp_addr = '0;
    logic        disp_ready;
    logic        disp_rvalid;
    logic [31:0] disp_rdata;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] ram [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 pixel_clock = ~pixel_clock;

    vram_arbiter #(
        .ADDR_W(16), .DATA_W(32), .MAX_DISP_STREAK(4)
    ) dut (
        .pixel_clock(pixel_clock), .reset_n(reset_n), .in_blank(in_blank),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ready(disp_ready),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge pixel_clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[11:0]] = mem_wdata;
            else        mem_rdata <= ram[mem_addr[11:0]];
        end
    end

    typedef struct {
        logic        bl, dr;
        logic [15:0] da;
        logic        cr, cw;
        logic [15:0] ca;
        logic [31:0] cd;
        logic        dy, cy, me, mw;
        logic [15:0] ma;
        logic        drv;
        logic [31:0] dd;
        logic        crv;
        logic [31:0] cdat;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic bl, input logic dr, input logic [15:0] da,
                     input logic cr, input logic cw, input logic [15:0] ca, input logic [31:0] cd,
                     input logic dy, input logic cy, input logic me, input logic mw,
                     input logic [15:0] ma, input logic drv, input logic [31:0] dd,
                     input logic crv, input logic [31:0] cdat);
        vec_t x;
        x.bl = bl; x.dr = dr; x.da = da; x.cr = cr; x.cw = cw; x.ca = ca; x.cd = cd;
        x.dy = dy; x.cy = cy; x.me = me; x.mw = mw; x.ma = ma;
        x.drv = drv; x.dd = dd; x.crv = crv; x.cdat = cdat;
        vq.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n, input logic [15:0] ma_unused);
        for (int k = 0; k < n; k++) v(0,0,16'h0, 0,0,16'h0,32'h0, 0,0,0,0,ma_unused, 0,32'h0, 0,32'h0);
    endtask

    initial begin
        int grant_cyc;
        for (int a = 0; a < 4096; a++) ram[a] = 32'hA500_0000 | a;
        ram[12'h030] = 32'h0000_000A;
        ram[12'h031] = 32'h0000_000B;
        ram[12'h032] = 32'h0000_000C;

        //  bl dr da        cr cw ca        cd             dy cy me mw ma        drv dd             crv cdat
        // display-only burst
        v(0,1,16'h0010, 0,0,16'h0000,32'h0,            1,0,0,0,16'h0000, 0,32'h0,          0,32'h0);
        v(0,1,16'h0011, 0,0,16'h0000,32'h0,            1,0,1,0,16'h0010, 0,32'h0,          0,32'h0);
        v(0,1,16'h0012, 0,0,16'h0000,32'h0,            1,0,1,0,16'h0011, 0,32'h0,          0,32'h0);
        v(0,1,16'h0013, 0,0,16'h0000,32'h0,            1,0,1,0,16'h0012, 1,32'hA500_0010,  0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,1,0,16'h0013, 1,32'hA500_0011,  0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,0,0,16'h0000, 1,32'hA500_0012,  0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,0,0,16'h0000, 1,32'hA500_0013,  0,32'h0);
        idle(1, 16'h0);
        // contention outside blank: four display grants then the CPU write
        v(0,1,16'h0020, 1,1,16'h0100,32'hDEADBEEF,     1,0,0,0,16'h0000, 0,32'h0,          0,32'h0);
        v(0,1,16'h0020, 1,1,16'h0100,32'hDEADBEEF,     1,0,1,0,16'h0020, 0,32'h0,          0,32'h0);
        v(0,1,16'h0020, 1,1,16'h0100,32'hDEADBEEF,     1,0,1,0,16'h0020, 0,32'h0,          0,32'h0);
        v(0,1,16'h0020, 1,1,16'h0100,32'hDEADBEEF,     1,0,1,0,16'h0020, 1,32'hA500_0020,  0,32'h0);
        v(0,1,16'h0020, 1,1,16'h0100,32'hDEADBEEF,     0,1,1,0,16'h0020, 1,32'hA500_0020,  0,32'h0);
        v(0,1,16'h0020, 0,0,16'h0000,32'h0,            1,0,1,1,16'h0100, 1,32'hA500_0020,  0,32'h0);
        v(0,1,16'h0020, 0,0,16'h0000,32'h0,            1,0,1,0,16'h0020, 1,32'hA500_0020,  0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,1,0,16'h0020, 0,32'h0,          0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,0,0,16'h0000, 1,32'hA500_0020,  0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,0,0,16'h0000, 1,32'hA500_0020,  0,32'h0);
        idle(1, 16'h0);
        // contention in blank: CPU wins while it keeps requesting
        v(1,1,16'h0021, 1,0,16'h0030,32'h0,            0,1,0,0,16'h0000, 0,32'h0,          0,32'h0);
        v(1,1,16'h0021, 1,0,16'h0031,32'h0,            0,1,1,0,16'h0030, 0,32'h0,          0,32'h0);
        v(1,1,16'h0021, 0,0,16'h0000,32'h0,            1,0,1,0,16'h0031, 0,32'h0,          0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,1,0,16'h0021, 0,32'h0,          1,32'h0000_000A);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,0,0,16'h0000, 0,32'h0,          1,32'h0000_000B);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,0,0,16'h0000, 1,32'hA500_0021,  0,32'h0);
        idle(1, 16'h0);
        // alternating owners
        v(0,0,16'h0000, 1,0,16'h0030,32'h0,            0,1,0,0,16'h0000, 0,32'h0,          0,32'h0);
        v(0,1,16'h0031, 0,0,16'h0000,32'h0,            1,0,1,0,16'h0030, 0,32'h0,          0,32'h0);
        v(0,0,16'h0000, 1,0,16'h0032,32'h0,            0,1,1,0,16'h0031, 0,32'h0,          0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,1,0,16'h0032, 0,32'h0,          1,32'h0000_000A);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,0,0,16'h0000, 1,32'h0000_000B,  0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,0,0,16'h0000, 0,32'h0,          1,32'h0000_000C);
        idle(1, 16'h0);
        // CPU write then read of the same word
        v(0,0,16'h0000, 1,1,16'h0200,32'h12345678,     0,1,0,0,16'h0000, 0,32'h0,          0,32'h0);
        v(0,0,16'h0000, 1,0,16'h0200,32'h0,            0,1,1,1,16'h0200, 0,32'h0,          0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,1,0,16'h0200, 0,32'h0,          0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,0,0,16'h0000, 0,32'h0,          0,32'h0);
        v(0,0,16'h0000, 0,0,16'h0000,32'h0,            0,0,0,0,16'h0000, 0,32'h0,          1,32'h12345678);
        idle(1, 16'h0);

        repeat (2) @(negedge pixel_clock);
        #1;
        chk("reset_disp_ready", {31'b0, disp_ready}, 32'h0);
        chk("reset_mem_en", {31'b0, mem_en}, 32'h0);
        chk("reset_mem_addr", {16'b0, mem_addr}, 32'h0);
        @(negedge pixel_clock);
        reset_n = 1'b1;

        foreach (vq[i]) begin
            if (i > 0) @(negedge pixel_clock);
            in_blank = vq[i].bl; disp_req = vq[i].dr; disp_addr = vq[i].da;
            cpu_req = vq[i].cr; cpu_we = vq[i].cw; cpu_addr = vq[i].ca; cpu_wdata = vq[i].cd;
            #1;
            chk($sformatf("r%0d_disp_ready", i), {31'b0, disp_ready}, {31'b0, vq[i].dy});
            chk($sformatf("r%0d_cpu_ready", i), {31'b0, cpu_ready}, {31'b0, vq[i].cy});
            chk($sformatf("r%0d_mem_en", i), {31'b0, mem_en}, {31'b0, vq[i].me});
            chk($sformatf("r%0d_disp_rvalid", i), {31'b0, disp_rvalid}, {31'b0, vq[i].drv});
            chk($sformatf("r%0d_cpu_rvalid", i), {31'b0, cpu_rvalid}, {31'b0, vq[i].crv});
            if (vq[i].me) begin
                chk($sformatf("r%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vq[i].mw});
                chk($sformatf("r%0d_mem_addr", i), {16'b0, mem_addr}, {16'b0, vq[i].ma});
            end
            if (vq[i].drv) chk($sformatf("r%0d_disp_rdata", i), disp_rdata, vq[i].dd);
            if (vq[i].crv) chk($sformatf("r%0d_cpu_rdata", i), cpu_rdata, vq[i].cdat);
        end

        // build a display streak of three, then reset one cycle after the last display grant
        for (int k = 0; k < 3; k++) begin
            @(negedge pixel_clock);
            in_blank = 1'b0; disp_req = 1'b1; disp_addr = 16'h0010;
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 32'h0000_0055;
            #1;
            chk($sformatf("pre_rst_disp_ready_%0d", k), {31'b0, disp_ready}, 32'h1);
        end
        @(negedge pixel_clock);
        reset_n = 1'b0;
        #1;
        chk("rst_disp_ready", {31'b0, disp_ready}, 32'h0);
        chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_disp_rvalid", {31'b0, disp_rvalid}, 32'h0);
        chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        chk("rst_disp_rdata", disp_rdata, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        @(negedge pixel_clock);
        #1;
        chk("rst_hold_disp_rvalid", {31'b0, disp_rvalid}, 32'h0);
        @(negedge pixel_clock);
        reset_n = 1'b1;
        grant_cyc = -1;
        for (int c = 0; c < 8 && grant_cyc < 0; c++) begin
            if (c > 0) @(negedge pixel_clock);
            #1;
            if (c < 3) chk($sformatf("post_rst_disp_rvalid_%0d", c), {31'b0, disp_rvalid}, 32'h0);
            if (cpu_ready) grant_cyc = c;
        end
        chk("post_rst_cpu_grant_cycle", grant_cyc, 32'd4);

        @(negedge pixel_clock);
        disp_req = 1'b0; cpu_req = 1'b0;
        repeat (5) @(negedge pixel_clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
